// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock button front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

  // Debounce channel states; bit 1 set means the button is considered held
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } debounce_state_t;

  localparam int LOCK_SYNC_STAGES     = 2;
  localparam int LOCK_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/lock_debounce_channel.sv
// One button: synchroniser, debounce FSM and sample counter; flags a qualified press.
// Latency: o_press is high during the cycle whose edge is SYNC_STAGES+DEBOUNCE_CYCLES after raw rises.
// Backpressure: none; o_press is a one-cycle strobe that the consumer must take when offered.
module lock_debounce_channel
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES     = LOCK_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = LOCK_DEBOUNCE_CYCLES
) (
  input  logic i_clock,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press,
  output logic o_busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  debounce_state_t        r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Metastability guard: the raw pin feeds only the first stage of this shift register
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Debounce FSM; r_cnt holds how many consecutive agreeing samples have been seen
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RELEASED: begin
          if (w_s) begin
            // A single qualifying sample is enough when DEBOUNCE_CYCLES is 1
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= PRESSED;
              r_cnt   <= '0;
            end else begin
              r_state <= PRESS_WAIT;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= RELEASED;
              r_cnt   <= '0;
            end else begin
              r_state <= RELEASE_WAIT;
              r_cnt   <= CNT_ONE;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A high sample here is release bounce: go back to held without a new press
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Press strobe is decoded from the transition into PRESSED so the top can register it on the same edge
  assign o_press = w_s && (((r_state == PRESS_WAIT) && (r_cnt == CNT_LAST)) ||
                           ((DEBOUNCE_CYCLES == 1) && (r_state == RELEASED)));
  assign o_busy  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

endmodule

// File: rtl/lock_button_conditioner.sv
// Two-button conditioner: debounced single-cycle presses for the lock FSM, overlapping presses rejected.
// Latency: output pulse in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 1 = first raw-high sample).
// Backpressure: none; pulses are fire-and-forget, the lock FSM must consume them in that cycle.
module lock_button_conditioner
  import lock_pkg::*;
#(
  parameter int SYNC_STAGES     = LOCK_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = LOCK_DEBOUNCE_CYCLES
) (
  input  logic i_clock,
  input  logic i_rst,
  input  logic i_raw_button_0,
  input  logic i_raw_button_1,
  output logic o_button_0,
  output logic o_button_1,
  output logic o_conflict
);

  logic w_press_0;
  logic w_press_1;
  logic w_busy_0;
  logic w_busy_1;
  logic r_button_0;
  logic r_button_1;
  logic r_conflict;

  lock_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_0 (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .i_raw   (i_raw_button_0),
    .o_press (w_press_0),
    .o_busy  (w_busy_0)
  );

  lock_debounce_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_1 (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .i_raw   (i_raw_button_1),
    .o_press (w_press_1),
    .o_busy  (w_busy_1)
  );

  // Arbitration: a press only passes when the other button is neither pressing now nor held
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_button_0 <= 1'b0;
      r_button_1 <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_button_0 <= w_press_0 && !w_press_1 && !w_busy_1;
      r_button_1 <= w_press_1 && !w_press_0 && !w_busy_0;
      r_conflict <= (w_press_0 && (w_press_1 || w_busy_1)) ||
                    (w_press_1 && (w_press_0 || w_busy_0));
    end
  end

  assign o_button_0 = r_button_0;
  assign o_button_1 = r_button_1;
  assign o_conflict = r_conflict;

endmodule

// File: tb/tb_lock_button_conditioner.sv
// Bench for lock_button_conditioner at default parameters.
// Vector table applied per cycle; expected outputs queued at drive time and popped after the edge.
// Hand-written sequence covers reset arriving mid-debounce.
module tb_lock_button_conditioner;

  logic clock;
  logic rst;
  logic raw_button_0;
  logic raw_button_1;
  logic button_0;
  logic button_1;
  logic conflict;

  lock_button_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clock        (clock),
    .i_rst          (rst),
    .i_raw_button_0 (raw_button_0),
    .i_raw_button_1 (raw_button_1),
    .o_button_0     (button_0),
    .o_button_1     (button_1),
    .o_conflict     (conflict)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // exp is {button_0, button_1, conflict} expected right after the edge that samples the inputs
  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [2:0] exp;
    string      tag;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];
  int         n_cmp;
  int         n_bad;

  function automatic void add(input logic v_rst, input logic v_r0, input logic v_r1,
                              input logic [2:0] v_exp, input string v_tag);
    vec_t v;
    v.rst = v_rst;
    v.r0  = v_r0;
    v.r1  = v_r1;
    v.exp = v_exp;
    v.tag = v_tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, want);
    end
  endtask

  initial begin
    logic [0:5] b_pat;
    logic [0:5] r_pat;
    logic [2:0] got;
    logic [2:0] want;
    int         first_at;
    int         pulses;
    int         others;

    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    raw_button_0 = 1'b0;
    raw_button_1 = 1'b0;

    // Reset with toggling inputs, then quiet
    for (int i = 0; i < 3; i++) add(1'b1, logic'(i % 2), logic'((i + 1) % 2), 3'b000, "reset_hold");
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 1'b0, 3'b000, "reset_idle");

    // Clean press on button 1: single pulse at edge 6, none while held
    for (int k = 1; k <= 20; k++) add(1'b0, 1'b0, 1'b1, (k == 6) ? 3'b010 : 3'b000, "clean_b1");
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, 3'b000, "clean_rel");

    // Press bounce 1,1,0,1,1,0 then stable from vector 7; pulse 6 edges into the stable run
    b_pat = 6'b110110;
    for (int k = 0; k < 6; k++) add(1'b0, b_pat[k], 1'b0, 3'b000, "bounce_press");
    for (int k = 7; k <= 20; k++) add(1'b0, 1'b1, 1'b0, (k == 12) ? 3'b100 : 3'b000, "bounce_press");
    // Release bounce must not produce another pulse
    r_pat = 6'b010000;
    for (int k = 0; k < 6; k++) add(1'b0, r_pat[k], 1'b0, 3'b000, "bounce_rel");
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, 3'b000, "bounce_rel");

    // Simultaneous press: conflict only
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b1, 1'b1, (k == 6) ? 3'b001 : 3'b000, "simul");
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, 3'b000, "simul_rel");

    // Overlap: button 0 held, button 1 arrives at edge 10 -> conflict at edge 15
    for (int k = 1; k <= 30; k++)
      add(1'b0, 1'b1, logic'(k >= 10),
          (k == 6) ? 3'b100 : ((k == 15) ? 3'b001 : 3'b000), "overlap");
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, 3'b000, "overlap_rel");
    for (int k = 1; k <= 10; k++) add(1'b0, 1'b0, 1'b1, (k == 6) ? 3'b010 : 3'b000, "overlap_b1");
    for (int k = 1; k <= 12; k++) add(1'b0, 1'b0, 1'b0, 3'b000, "overlap_b1_rel");

    // Apply table: push expectation when driving, pop and compare after the edge
    foreach (vecs[i]) begin
      @(negedge clock);
      rst          = vecs[i].rst;
      raw_button_0 = vecs[i].r0;
      raw_button_1 = vecs[i].r1;
      exp_q.push_back(vecs[i].exp);
      @(posedge clock);
      #1;
      got  = {button_0, button_1, conflict};
      want = exp_q.pop_front();
      check($sformatf("%s[%0d]", vecs[i].tag, i), 32'(got), 32'(want));
    end

    // Reset arriving mid-debounce: raw 0 held high, reset at edge 4 for one cycle
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      rst          = (k == 4);
      raw_button_0 = 1'b1;
      raw_button_1 = 1'b0;
      @(posedge clock);
      #1;
      check($sformatf("rstmid_pre[%0d]", k), 32'({button_0, button_1, conflict}), 32'(3'b000));
    end
    first_at = 0;
    pulses   = 0;
    others   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      rst = 1'b0;
      @(posedge clock);
      #1;
      if (button_0 === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = n;
      end
      if (button_1 !== 1'b0 || conflict !== 1'b0) others++;
    end
    check("rstmid_latency", 32'(first_at), 32'd6);
    check("rstmid_pulses", 32'(pulses), 32'd1);
    check("rstmid_others", 32'(others), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
